reorder_buffer_param: RTL and testbench
=======================================

// Module: reorder_buffer_param
// PURPOSE
//  Parametrised reorder buffer (ROB) for the out-of-order pipelined processor.
//  - Allocates entries in program order at dispatch.
//  - Accepts out-of-order results from N_WB writeback ports.
//  - Retires one completed entry per cycle, in order, to the register file.
//  - Clears the whole window when a mispredicted branch retires.
//  Sits between the control/dispatch stage and the register-file write port of the datapath.
// PARAMETERS
//  DEPTH   8   number of entries; power of 2, >= 2
//  DATA_W  64  result data width
//  REG_W   5   architectural destination register index width
//  N_WB    2   number of writeback ports, >= 1
//  (IDX_W = $clog2(DEPTH) is derived, not a parameter)
// PORTS
//  clk              in   1             rising-edge clock
//  reset            in   1             asynchronous, active-high reset
//  alloc_valid      in   1             dispatch requests an entry
//  alloc_ready      out  1             entry available this cycle
//  alloc_dest_reg   in   REG_W         destination register of dispatched instr
//  alloc_reg_write  in   1             instr writes the register file
//  alloc_is_branch  in   1             instr is a branch
//  alloc_tag        out  IDX_W         tag (entry index) assigned on alloc fire
//  wb_valid         in   N_WB          per-port result valid
//  wb_tag           in   N_WB*IDX_W    per-port entry tag; port p at [p*IDX_W +: IDX_W]
//  wb_data          in   N_WB*DATA_W   per-port result; port p at [p*DATA_W +: DATA_W]
//  wb_mispredict    in   N_WB          per-port branch mispredict flag
//  commit_valid     out  1             head entry is complete and may retire
//  commit_ready     in   1             consumer accepts the retirement
//  commit_tag       out  IDX_W         head index
//  commit_dest_reg  out  REG_W         head destination register
//  commit_reg_write out  1             head writes the register file
//  commit_data      out  DATA_W        head result
//  flush            out  1             mispredicted branch retiring this cycle
//  count            out  IDX_W+1       occupied entries
//  empty            out  1             count == 0
//  full             out  1             count == DEPTH
// BEHAVIOUR
//  Reset (async, any time, including mid-operation):
//   - head = tail = count = 0; all entry valid/done/mispredict bits = 0.
//   - Outputs: alloc_ready=1, alloc_tag=0, commit_valid=0, commit_* = 0, flush=0, count=0, empty=1, full=0.
//  Storage: circular buffer; head = oldest entry, tail = next free entry. Pointers wrap DEPTH-1 -> 0.
//  Alloc:
//   - alloc_tag = tail (combinational).
//   - alloc_ready = !full && !flush.
//   - Fire = alloc_valid & alloc_ready. On fire: entry[tail] gets valid=1, done=0, mispredict=0, plus the fields; tail++.
//  Writeback:
//   - Port p with wb_valid[p] sets done=1, data, mispredict on entry[wb_tag[p]], only if that entry is valid and not being flushed.
//   - A writeback to an invalid entry is silently dropped. This includes the entry allocated in the same cycle.
//   - Same tag on two ports in one cycle: the highest port index wins.
//   - A re-writeback to a done entry overwrites it.
//  Commit (zero-latency on head):
//   - commit_valid = valid[head] & done[head]; commit_* fields come from entry[head].
//   - commit_* = 0 when commit_valid = 0.
//   - Fire = commit_valid & commit_ready. On fire: valid[head]=0; head++.
//  Flush:
//   - flush = commit fire & is_branch[head] & mispredict[head] (combinational).
//   - The branch itself retires normally.
//   - At the clock edge: all entries invalidated; head = tail = count = 0.
//   - Alloc is blocked and writebacks are dropped in the flush cycle.
//  Count: next = count + alloc_fire - commit_fire, or 0 on flush.
//   - Simultaneous alloc and commit leave count unchanged.
//   - No full bypass: when full, alloc_ready = 0 even if commit fires that cycle.
//  Latency:
//   - A writeback at cycle N can retire at cycle N+1 at the earliest.
//   - An alloc at cycle N is visible in count at N+1.
// TESTING
//  1 Reset then 8 allocs (DEPTH=8)
//    -> tags 0..7; full=1 and alloc_ready=0 after the 8th; count=8.
//  2 Writeback tags 3,1,0,2 with data 0xA3,0xA1,0xA0,0xA2, commit_ready=1
//    -> commit_valid only once tag 0 is done; retires 0xA0,0xA1,0xA2,0xA3 in order.
//  3 Same cycle: wb port0 tag5 data 0x11, port1 tag5 data 0x22
//    -> entry5 retires 0x22.
//  4 Wrap-around: 12 alloc/commit pairs at count=4
//    -> tags wrap 7 -> 0; count stays 4; data order preserved.
//  5 Branch at tag2 with wb_mispredict=1, tags 3..5 valid
//    -> flush=1 exactly in tag2's commit cycle; next cycle count=0, empty=1, alloc_tag=0.
//    -> late wb to tag4 is dropped.
//  6 Assert reset with 5 entries pending and commit_ready=1
//    -> all outputs immediately at reset values; no commit fire after release.

Source files
------------

// File: rtl/reorder_buffer_param.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order retire.
// A retiring mispredicted branch empties the whole window at the next edge.

// One ROB slot. Flush has priority, then allocation, then commit/writeback.
module rob_entry #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              alloc_we,
    input  logic [REG_W-1:0]  alloc_dest_reg,
    input  logic              alloc_reg_write,
    input  logic              alloc_is_branch,
    input  logic              wb_we,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_mispredict,
    input  logic              commit_clr,
    output logic              valid,
    output logic              done,
    output logic              mispredict,
    output logic              is_branch,
    output logic              reg_write,
    output logic [REG_W-1:0]  dest_reg,
    output logic [DATA_W-1:0] data
);
    // Slot state: allocation resets the status bits, writeback marks it complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid      <= 1'b0;
            done       <= 1'b0;
            mispredict <= 1'b0;
            is_branch  <= 1'b0;
            reg_write  <= 1'b0;
            dest_reg   <= '0;
            data       <= '0;
        end else if (flush) begin
            valid      <= 1'b0;
            done       <= 1'b0;
            mispredict <= 1'b0;
        end else if (alloc_we) begin
            valid      <= 1'b1;
            done       <= 1'b0;
            mispredict <= 1'b0;
            is_branch  <= alloc_is_branch;
            reg_write  <= alloc_reg_write;
            dest_reg   <= alloc_dest_reg;
        end else begin
            if (commit_clr) valid <= 1'b0;
            if (wb_we) begin
                done       <= 1'b1;
                data       <= wb_data;
                mispredict <= wb_mispredict;
            end
        end
    end
endmodule

module reorder_buffer_param #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64,
    parameter int REG_W  = 5,
    parameter int N_WB   = 2,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [REG_W-1:0]       alloc_dest_reg,
    input  logic                   alloc_reg_write,
    input  logic                   alloc_is_branch,
    output logic [IDX_W-1:0]       alloc_tag,
    input  logic [N_WB-1:0]        wb_valid,
    input  logic [N_WB*IDX_W-1:0]  wb_tag,
    input  logic [N_WB*DATA_W-1:0] wb_data,
    input  logic [N_WB-1:0]        wb_mispredict,
    output logic                   commit_valid,
    input  logic                   commit_ready,
    output logic [IDX_W-1:0]       commit_tag,
    output logic [REG_W-1:0]       commit_dest_reg,
    output logic                   commit_reg_write,
    output logic [DATA_W-1:0]      commit_data,
    output logic                   flush,
    output logic [IDX_W:0]         count,
    output logic                   empty,
    output logic                   full
);
    logic [IDX_W-1:0] head, tail;
    logic [IDX_W:0]   cnt;
    logic             alloc_fire, commit_fire, head_ok;

    logic [DEPTH-1:0]             e_valid, e_done, e_mis, e_br, e_rw;
    logic [DEPTH-1:0][REG_W-1:0]  e_dest;
    logic [DEPTH-1:0][DATA_W-1:0] e_data;

    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == (IDX_W+1)'(DEPTH));

    // Head retires as soon as it is complete; a mispredicted branch flushes.
    assign head_ok     = e_valid[head] & e_done[head];
    assign commit_fire = head_ok & commit_ready;
    assign flush       = commit_fire & e_br[head] & e_mis[head];

    // No full bypass: a full buffer refuses alloc even if head retires now.
    assign alloc_ready = !full && !flush;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign alloc_tag   = tail;

    assign commit_valid     = head_ok;
    assign commit_tag       = head_ok ? head         : '0;
    assign commit_dest_reg  = head_ok ? e_dest[head] : '0;
    assign commit_reg_write = head_ok & e_rw[head];
    assign commit_data      = head_ok ? e_data[head] : '0;

    // Pointers and occupancy; a flush returns the window to its reset shape.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (alloc_fire)  tail <= tail + 1'b1;
            if (commit_fire) head <= head + 1'b1;
            cnt <= cnt + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic              hit;
        logic [DATA_W-1:0] hit_data;
        logic              hit_mis;

        // Pick the writeback aimed at this slot; higher port index wins.
        always_comb begin
            hit      = 1'b0;
            hit_data = '0;
            hit_mis  = 1'b0;
            for (int p = 0; p < N_WB; p++) begin
                if (wb_valid[p] && wb_tag[p*IDX_W +: IDX_W] == IDX_W'(i)) begin
                    hit      = 1'b1;
                    hit_data = wb_data[p*DATA_W +: DATA_W];
                    hit_mis  = wb_mispredict[p];
                end
            end
        end

        rob_entry #(.DATA_W(DATA_W), .REG_W(REG_W)) u_ent (
            .clk             (clk),
            .reset           (reset),
            .flush           (flush),
            .alloc_we        (alloc_fire && tail == IDX_W'(i)),
            .alloc_dest_reg  (alloc_dest_reg),
            .alloc_reg_write (alloc_reg_write),
            .alloc_is_branch (alloc_is_branch),
            .wb_we           (hit && e_valid[i] && !flush),
            .wb_data         (hit_data),
            .wb_mispredict   (hit_mis),
            .commit_clr      (commit_fire && head == IDX_W'(i)),
            .valid           (e_valid[i]),
            .done            (e_done[i]),
            .mispredict      (e_mis[i]),
            .is_branch       (e_br[i]),
            .reg_write       (e_rw[i]),
            .dest_reg        (e_dest[i]),
            .data            (e_data[i])
        );
    end
endmodule

// File: tb/tb_reorder_buffer_param.sv
// Directed bench for reorder_buffer_param with a commit-side scoreboard.
module tb_reorder_buffer_param;
    localparam int DEPTH = 8, DATA_W = 64, REG_W = 5, N_WB = 2, IDX_W = 3;

    logic                   clk, reset;
    logic                   alloc_valid, alloc_ready, alloc_reg_write, alloc_is_branch;
    logic [REG_W-1:0]       alloc_dest_reg;
    logic [IDX_W-1:0]       alloc_tag;
    logic [N_WB-1:0]        wb_valid, wb_mispredict;
    logic [N_WB*IDX_W-1:0]  wb_tag;
    logic [N_WB*DATA_W-1:0] wb_data;
    logic                   commit_valid, commit_ready, commit_reg_write, flush;
    logic [IDX_W-1:0]       commit_tag;
    logic [REG_W-1:0]       commit_dest_reg;
    logic [DATA_W-1:0]      commit_data;
    logic [IDX_W:0]         count;
    logic                   empty, full;

    reorder_buffer_param #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .N_WB(N_WB)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_dest_reg(alloc_dest_reg),
        .alloc_reg_write(alloc_reg_write), .alloc_is_branch(alloc_is_branch), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_mispredict(wb_mispredict),
        .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
        .commit_dest_reg(commit_dest_reg), .commit_reg_write(commit_reg_write),
        .commit_data(commit_data), .flush(flush), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              fl;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int tag, input logic [DATA_W-1:0] d, input logic fl);
        exp_t e;
        e.tag  = IDX_W'(tag);
        e.data = d;
        e.fl   = fl;
        sb.push_back(e);
    endtask

    task automatic drive_idle();
        alloc_valid   = 1'b0;
        wb_valid      = '0;
        wb_mispredict = '0;
    endtask

    // Dest register is always tag+1 so the monitor can derive it from the tag.
    task automatic set_alloc(input int tag, input logic br);
        alloc_valid     = 1'b1;
        alloc_dest_reg  = REG_W'(tag + 1);
        alloc_reg_write = 1'b1;
        alloc_is_branch = br;
    endtask

    task automatic set_wb(input int p, input int tag, input logic [DATA_W-1:0] d, input logic m);
        wb_valid[p]                  = 1'b1;
        wb_tag[p*IDX_W +: IDX_W]     = IDX_W'(tag);
        wb_data[p*DATA_W +: DATA_W]  = d;
        wb_mispredict[p]             = m;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_alloc_ready"}, alloc_ready, 1);
        chk({pfx, "_alloc_tag"}, alloc_tag, 0);
        chk({pfx, "_commit_valid"}, commit_valid, 0);
        chk({pfx, "_commit_tag"}, commit_tag, 0);
        chk({pfx, "_commit_data"}, commit_data, 0);
        chk({pfx, "_commit_dest"}, commit_dest_reg, 0);
        chk({pfx, "_commit_rw"}, commit_reg_write, 0);
        chk({pfx, "_flush"}, flush, 0);
        chk({pfx, "_count"}, count, 0);
        chk({pfx, "_empty"}, empty, 1);
        chk({pfx, "_full"}, full, 0);
    endtask

    // Monitor: every retirement must match the oldest expected entry.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && commit_valid && commit_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", {61'b0, commit_tag}, 64'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("commit_tag", commit_tag, e.tag);
                chk("commit_data", commit_data, e.data);
                chk("commit_dest", commit_dest_reg, REG_W'(e.tag + 1));
                chk("commit_rw", commit_reg_write, 1);
                chk("commit_flush", flush, e.fl);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t2_tag[4];
        logic [DATA_W-1:0] t2_dat[4];
        t2_tag = '{3, 1, 0, 2};
        t2_dat = '{64'hA3, 64'hA1, 64'hA0, 64'hA2};
        clk = 0;
        reset = 0;
        commit_ready = 0;
        alloc_dest_reg = '0; alloc_reg_write = 0; alloc_is_branch = 0;
        wb_tag = '0; wb_data = '0;
        drive_idle();
        #1 reset = 1;
        #1 chk_reset_outputs("reset");
        @(posedge clk); #1 reset = 0;

        // 1: fill all eight slots
        for (int i = 0; i < 8; i++) begin
            set_alloc(i, 0);
            @(negedge clk);
            chk("t1_tag", alloc_tag, i);
            chk("t1_ready", alloc_ready, 1);
            next();
        end
        set_alloc(0, 0);
        @(negedge clk);
        chk("t1_full", full, 1);
        chk("t1_ready_full", alloc_ready, 0);
        next();
        @(negedge clk);
        chk("t1_count", count, 8);

        // 2: out-of-order writebacks, in-order retirement
        commit_ready = 1;
        for (int t = 0; t < 4; t++) push(t, 64'hA0 + t, 0);
        for (int k = 0; k < 4; k++) begin
            set_wb(0, t2_tag[k], t2_dat[k], 0);
            @(negedge clk);
            if (k <= 2) chk("t2_hold", commit_valid, 0);
            next();
        end
        repeat (4) next();
        @(negedge clk);
        chk("t2_count", count, 4);

        // 3: same tag on both ports, port 1 wins
        push(4, 64'h44, 0);
        push(5, 64'h22, 0);
        set_wb(0, 5, 64'h11, 0);
        set_wb(1, 5, 64'h22, 0);
        @(negedge clk);
        chk("t3_hold", commit_valid, 0);
        next();
        set_wb(0, 4, 64'h44, 0);
        next();
        repeat (3) next();
        @(negedge clk);
        chk("t3_count", count, 2);

        // 4: steady alloc/commit pairs at count 4, tags wrap 7 -> 0
        commit_ready = 0;
        set_alloc(0, 0); next();
        set_alloc(1, 0); next();
        set_wb(0, 6, 64'h100, 0); set_wb(1, 7, 64'h101, 0); next();
        set_wb(0, 0, 64'h102, 0); set_wb(1, 1, 64'h103, 0); next();
        push(6, 64'h100, 0); push(7, 64'h101, 0); push(0, 64'h102, 0); push(1, 64'h103, 0);
        @(negedge clk);
        chk("t4_count_pre", count, 4);
        @(posedge clk); #1;
        commit_ready = 1;
        for (int k = 0; k < 12; k++) begin
            set_alloc((2 + k) % 8, 0);
            push((2 + k) % 8, 64'h104 + k, 0);
            if (k > 0) set_wb(0, (1 + k) % 8, 64'h103 + k, 0);
            @(negedge clk);
            chk("t4_tag", alloc_tag, (2 + k) % 8);
            chk("t4_count", count, 4);
            chk("t4_cvalid", commit_valid, 1);
            next();
        end
        set_wb(0, 5, 64'h10F, 0);
        next();
        repeat (4) next();
        @(negedge clk);
        chk("t4_empty", empty, 1);
        chk("t4_count_end", count, 0);

        // 5: mispredicted branch at tag 2 flushes the window
        @(posedge clk); #1 reset = 1;
        next();
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            set_alloc(i, i == 2);
            next();
        end
        push(0, 64'hB0, 0); push(1, 64'hB1, 0); push(2, 64'hB2, 1);
        set_wb(0, 0, 64'hB0, 0); next();
        set_wb(0, 1, 64'hB1, 0); next();
        set_wb(0, 3, 64'hB3, 0); next();
        set_wb(0, 2, 64'hB2, 1);
        @(negedge clk);
        chk("t5_no_early_flush", flush, 0);
        next();
        set_alloc(6, 0);
        set_wb(0, 4, 64'hB4, 0);
        @(negedge clk);
        chk("t5_flush", flush, 1);
        chk("t5_alloc_blocked", alloc_ready, 0);
        chk("t5_count_pre", count, 4);
        next();
        @(negedge clk);
        chk("t5_count", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_alloc_tag", alloc_tag, 0);
        chk("t5_cvalid", commit_valid, 0);
        chk("t5_flush_off", flush, 0);
        @(posedge clk); #1;
        // writeback to the slot being allocated this cycle is dropped
        set_alloc(0, 0);
        set_wb(0, 0, 64'hEE, 0);
        next();
        @(negedge clk);
        chk("t5_same_cycle_drop", commit_valid, 0);
        chk("t5_count_one", count, 1);
        @(posedge clk); #1;
        push(0, 64'h55, 0);
        set_wb(0, 0, 64'h55, 0);
        next();
        next();
        @(negedge clk);
        chk("t5_empty_end", empty, 1);

        // 6: asynchronous reset with completed entries pending
        @(posedge clk); #1;
        commit_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            set_alloc(i, 0);
            next();
        end
        for (int i = 1; i <= 5; i++) begin
            set_wb(0, i, 64'hC0 + i, 0);
            next();
        end
        @(negedge clk);
        chk("t6_count", count, 5);
        chk("t6_cvalid", commit_valid, 1);
        @(posedge clk); #1;
        commit_ready = 1;
        #1 reset = 1;
        #1 chk_reset_outputs("t6_reset");
        next();
        reset = 0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_commit", commit_valid, 0);
            next();
        end

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
